// File: rtl/led_panel_pkg.sv
// Shared types and widths for the HUB75 scan controller slice.
package led_panel_pkg;

  localparam int unsigned RGB_W = 6;  // R0G0B0R1G1B1 slice
  localparam int unsigned SEL_W = 2;  // bit-plane select width

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    TAIL,
    LATCH,
    DISP
  } scan_state_e;

endpackage

// File: rtl/led_panel_scan_ctrl_if.sv
// Frame-RAM / bit-plane mux side and panel connector side of the scan controller.
interface led_panel_scan_ctrl_if #(
  parameter int unsigned COL_BITS = 6,
  parameter int unsigned ROW_BITS = 5
) ();
  import led_panel_pkg::*;

  logic                         en;
  logic [ROW_BITS+COL_BITS-1:0] mem_addr;
  logic [SEL_W-1:0]             sel;
  logic [RGB_W-1:0]             rgb_in;
  logic [RGB_W-1:0]             rgb_out;
  logic                         panel_clk;
  logic                         panel_lat;
  logic                         panel_oe_n;
  logic [ROW_BITS-1:0]          row_addr;
  logic                         frame_start;

  modport master (
    input  en, rgb_in,
    output mem_addr, sel, rgb_out, panel_clk, panel_lat, panel_oe_n, row_addr, frame_start
  );

  modport slave (
    output en, rgb_in,
    input  mem_addr, sel, rgb_out, panel_clk, panel_lat, panel_oe_n, row_addr, frame_start
  );

endinterface

// File: rtl/bcm_oe_timer.sv
// BCM on-time down-counter: loads BASE_OE << plane, counts while running, flags zero.
module bcm_oe_timer
  import led_panel_pkg::*;
#(
  parameter int unsigned BASE_OE = 8,
  parameter int unsigned CNT_W   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_run,
  input  logic [SEL_W-1:0] i_plane,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  // Load the plane's on-time, then decrement once per running cycle down to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(BASE_OE) << i_plane;
    end else if (i_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_done = i_run && (r_cnt == '0);

endmodule

// File: rtl/led_panel_scan_ctrl.sv
// HUB75 scan controller: shifts one row/plane, latches it, then holds OE low for a BCM-weighted time.
module led_panel_scan_ctrl
  import led_panel_pkg::*;
#(
  parameter int unsigned COL_BITS = 6,
  parameter int unsigned ROW_BITS = 5,
  parameter int unsigned PLANES   = 4,
  parameter int unsigned BASE_OE  = 8
) (
  input logic                   clk,
  input logic                   rst,
  led_panel_scan_ctrl_if.master bus
);

  localparam int unsigned CNT_W = $clog2(BASE_OE << (PLANES - 1)) + 1;

  scan_state_e r_state, w_state_nxt;

  logic [COL_BITS-1:0] r_col;
  logic                r_ph;
  logic [SEL_W-1:0]    r_plane;
  logic [ROW_BITS-1:0] r_row;

  logic [ROW_BITS+COL_BITS-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [RGB_W-1:0]             r_rgb_out, w_rgb_out_nxt;
  logic                         r_panel_clk, w_panel_clk_nxt;
  logic                         r_panel_lat, w_panel_lat_nxt;
  logic                         r_panel_oe_n, w_panel_oe_n_nxt;
  logic [ROW_BITS-1:0]          r_row_addr, w_row_addr_nxt;
  logic                         r_frame_start, w_frame_start_nxt;

  logic                w_last_col;
  logic                w_plane_wrap;
  logic [SEL_W-1:0]    w_plane_adv;
  logic [ROW_BITS-1:0] w_row_adv;
  logic                w_oe_done;

  assign w_last_col   = (r_col == COL_BITS'(2**COL_BITS - 1));
  assign w_plane_wrap = (r_plane == SEL_W'(PLANES - 1));
  assign w_plane_adv  = w_plane_wrap ? '0 : r_plane + SEL_W'(1);
  assign w_row_adv    = w_plane_wrap ? r_row + ROW_BITS'(1) : r_row;

  bcm_oe_timer #(
    .BASE_OE (BASE_OE),
    .CNT_W   (CNT_W)
  ) u_oe_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (r_state == LATCH),
    .i_run   (r_state == DISP),
    .i_plane (r_plane),
    .o_done  (w_oe_done)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: one shift/latch/display pass per plane, continue only while enabled
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.en) w_state_nxt = SHIFT;
      SHIFT:   if (r_ph && w_last_col) w_state_nxt = TAIL;
      TAIL:    w_state_nxt = LATCH;
      LATCH:   w_state_nxt = DISP;
      DISP:    if (w_oe_done) w_state_nxt = bus.en ? SHIFT : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Column/phase/plane/row counters; plane and row only move once a display window ends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col   <= '0;
      r_ph    <= 1'b0;
      r_plane <= '0;
      r_row   <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.en) begin
          r_col <= '0;
          r_ph  <= 1'b0;
        end
        SHIFT: begin
          r_ph <= ~r_ph;
          if (r_ph) r_col <= r_col + COL_BITS'(1);
        end
        DISP: if (w_oe_done) begin
          r_plane <= w_plane_adv;
          r_row   <= w_row_adv;
          r_col   <= '0;
          r_ph    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Output decode: next values for the registered panel/RAM outputs
  always_comb begin
    w_mem_addr_nxt    = r_mem_addr;
    w_rgb_out_nxt     = r_rgb_out;
    w_row_addr_nxt    = r_row_addr;
    w_panel_clk_nxt   = 1'b0;
    w_panel_lat_nxt   = 1'b0;
    w_panel_oe_n_nxt  = 1'b1;
    w_frame_start_nxt = 1'b0;
    case (r_state)
      IDLE: w_frame_start_nxt = bus.en && (r_row == '0) && (r_plane == '0);
      SHIFT: begin
        if (!r_ph) begin
          w_mem_addr_nxt  = {r_row, r_col};
          // rising edge here clocks in the column captured on the previous ph=1
          w_panel_clk_nxt = (r_col != '0);
        end else begin
          w_rgb_out_nxt = bus.rgb_in;
        end
      end
      TAIL:  w_panel_clk_nxt = 1'b1;
      LATCH: begin
        w_panel_lat_nxt = 1'b1;
        w_row_addr_nxt  = r_row;
      end
      DISP: begin
        if (!w_oe_done) w_panel_oe_n_nxt = 1'b0;
        else w_frame_start_nxt = bus.en && (w_row_adv == '0) && (w_plane_adv == '0);
      end
      default: ;
    endcase
  end

  // Output registers; reset blanks the panel immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_addr    <= '0;
      r_rgb_out     <= '0;
      r_panel_clk   <= 1'b0;
      r_panel_lat   <= 1'b0;
      r_panel_oe_n  <= 1'b1;
      r_row_addr    <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_mem_addr    <= w_mem_addr_nxt;
      r_rgb_out     <= w_rgb_out_nxt;
      r_panel_clk   <= w_panel_clk_nxt;
      r_panel_lat   <= w_panel_lat_nxt;
      r_panel_oe_n  <= w_panel_oe_n_nxt;
      r_row_addr    <= w_row_addr_nxt;
      r_frame_start <= w_frame_start_nxt;
    end
  end

  assign bus.mem_addr    = r_mem_addr;
  assign bus.sel         = r_plane;
  assign bus.rgb_out     = r_rgb_out;
  assign bus.panel_clk   = r_panel_clk;
  assign bus.panel_lat   = r_panel_lat;
  assign bus.panel_oe_n  = r_panel_oe_n;
  assign bus.row_addr    = r_row_addr;
  assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_led_panel_scan_ctrl.sv
// Bench for led_panel_scan_ctrl: random frame data, random enable pattern, pass-level reference model.
module tb_led_panel_scan_ctrl;

  localparam int unsigned COL_BITS = 2;
  localparam int unsigned ROW_BITS = 1;
  localparam int unsigned PLANES   = 4;
  localparam int unsigned BASE_OE  = 2;
  localparam int unsigned COLS     = 2**COL_BITS;
  localparam int unsigned ROWS     = 2**ROW_BITS;

  logic clk;
  logic rst;

  int n_chk = 0;
  int n_err = 0;

  led_panel_scan_ctrl_if #(.COL_BITS(COL_BITS), .ROW_BITS(ROW_BITS)) bus ();

  led_panel_scan_ctrl #(
    .COL_BITS (COL_BITS),
    .ROW_BITS (ROW_BITS),
    .PLANES   (PLANES),
    .BASE_OE  (BASE_OE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame RAM + bit-plane mux: the controller's registered address acts as the RAM address register
  logic [5:0] ram [PLANES][ROWS*COLS];
  assign bus.rgb_in = ram[bus.sel][bus.mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pass k shows plane k%PLANES of row (k/PLANES)%ROWS
  logic [5:0]  shq[$];
  int unsigned p_idx;
  int unsigned oe_w;
  logic        prev_clk, prev_oe, seen_fs;

  always @(negedge clk) begin
    int unsigned pl, rw;
    logic [31:0] got_v, exp_v;
    if (rst) begin
      shq.delete();
      p_idx    = 0;
      oe_w     = 0;
      prev_clk = 1'b0;
      prev_oe  = 1'b1;
      seen_fs  = 1'b0;
    end else begin
      pl = p_idx % PLANES;
      rw = (p_idx / PLANES) % ROWS;
      check("lat_oe_excl", 32'(bus.panel_lat & ~bus.panel_oe_n), 0);
      check("clk_quiet", 32'(bus.panel_clk & (bus.panel_lat | ~bus.panel_oe_n)), 0);
      if (bus.frame_start) begin
        seen_fs = 1'b1;
        check("fs_at_pass_start", shq.size(), 0);
      end
      if (bus.panel_clk && !prev_clk) begin
        check("sel_during_shift", 32'(bus.sel), pl);
        shq.push_back(bus.rgb_out);
      end
      if (bus.panel_lat) begin
        got_v = '0;
        exp_v = '0;
        foreach (shq[i]) got_v |= 32'(shq[i]) << (6 * i);
        for (int unsigned c = 0; c < COLS; c++) exp_v |= 32'(ram[pl][rw*COLS + c]) << (6 * c);
        check("shift_bits", shq.size(), COLS);
        check("row_data", got_v, exp_v);
        check("row_addr", 32'(bus.row_addr), rw);
        check("frame_start", 32'(seen_fs), 32'((pl == 0) && (rw == 0)));
        shq.delete();
        seen_fs = 1'b0;
      end
      if (!bus.panel_oe_n) oe_w++;
      if (bus.panel_oe_n && !prev_oe) begin
        check("oe_width", oe_w, BASE_OE << pl);
        oe_w = 0;
        p_idx++;
      end
      prev_clk = bus.panel_clk;
      prev_oe  = bus.panel_oe_n;
    end
  end

  initial begin
    int unsigned n, rises, w, act;
    logic pclk;
    logic [ROW_BITS-1:0] t5_row;

    rst    = 1'b1;
    bus.en = 1'b0;
    foreach (ram[i, j]) ram[i][j] = 6'($urandom);

    // reset state
    repeat (3) @(negedge clk);
    check("rst_oe_n", 32'(bus.panel_oe_n), 1);
    check("rst_outs", 32'({bus.mem_addr, bus.sel, bus.rgb_out, bus.panel_clk,
                           bus.panel_lat, bus.row_addr, bus.frame_start}), 0);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_quiet", 32'({bus.panel_clk, bus.panel_lat, ~bus.panel_oe_n, bus.frame_start}), 0);

    // first pass: frame_start, address order, shift clock count, latch position
    #1 bus.en = 1'b1;
    @(negedge clk);
    check("t1_frame_start", 32'(bus.frame_start), 1);
    rises = 0;
    pclk  = bus.panel_clk;
    for (int unsigned i = 0; i < 2*COLS + 1; i++) begin
      @(negedge clk);
      if (i % 2 == 0 && i < 2*COLS) check("t1_mem_addr", 32'(bus.mem_addr), i / 2);
      if (bus.panel_clk && !pclk) rises++;
      pclk = bus.panel_clk;
    end
    check("t1_rises", rises, COLS);
    @(negedge clk);
    check("t1_lat", 32'(bus.panel_lat), 1);
    @(negedge clk);
    check("t1_lat_end", 32'(bus.panel_lat), 0);
    check("t1_oe_low", 32'(bus.panel_oe_n), 0);

    // free run across a full frame into the next one
    n = 0;
    while (p_idx < PLANES*ROWS + 2 && n < 3000) begin @(negedge clk); n++; end
    check("run_passes_wait", 32'(n < 3000), 1);

    // drop enable during plane 1 shifting, then resume
    n = 0;
    while (bus.sel != 0 && n < 500) begin @(negedge clk); n++; end
    while (bus.sel != 1 && n < 500) begin @(negedge clk); n++; end
    check("t5_reach_plane1", 32'(n < 500), 1);
    repeat (2) @(negedge clk);
    t5_row = bus.row_addr;
    #1 bus.en = 1'b0;
    n = 0;
    while (bus.panel_oe_n && n < 100) begin @(negedge clk); n++; end
    w = 0;
    while (!bus.panel_oe_n && w < 100) begin w++; @(negedge clk); end
    check("t5_oe_width", w, BASE_OE << 1);
    act = 0;
    repeat (20) begin
      @(negedge clk);
      act |= 32'({bus.panel_clk, bus.panel_lat, ~bus.panel_oe_n, bus.frame_start});
    end
    check("t5_idle", act, 0);
    check("t5_sel_held", 32'(bus.sel), 2);
    #1 bus.en = 1'b1;
    n = 0;
    while (!bus.panel_lat && n < 100) begin @(negedge clk); n++; end
    check("t5_resume_row", 32'(bus.row_addr), 32'(t5_row));
    check("t5_resume_sel", 32'(bus.sel), 2);

    // asynchronous reset in the middle of a display window
    n = 0;
    while (bus.panel_oe_n && n < 100) begin @(negedge clk); n++; end
    check("t6_reach_disp", 32'(n < 100), 1);
    #2 rst = 1'b1;
    bus.en = 1'b0;
    #1;
    check("t6_oe_n_async", 32'(bus.panel_oe_n), 1);
    check("t6_outs_async", 32'({bus.mem_addr, bus.sel, bus.rgb_out, bus.panel_clk,
                                bus.panel_lat, bus.row_addr, bus.frame_start}), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    act = 0;
    repeat (10) begin
      @(negedge clk);
      act |= 32'({bus.panel_clk, bus.panel_lat, ~bus.panel_oe_n, bus.frame_start});
    end
    check("t6_idle_after_rst", act, 0);
    #1 bus.en = 1'b1;
    n = 0;
    while (!bus.frame_start && n < 20) begin @(negedge clk); n++; end
    check("t6_frame_start", 32'(n < 20), 1);

    // random enable pattern; the monitor checks every pass
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(5, 60)) @(negedge clk);
      #1 bus.en = ($urandom_range(0, 3) != 0);
    end
    #1 bus.en = 1'b0;
    repeat (150) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
